// File: rtl/second_stage_controller_if.sv
// rtl/second_stage_controller_if.sv - lane write strobes, drain handshake and status of the z-vector cache sequencer
// The controller drives through master; the caches and downstream stage sit behind slave.
interface second_stage_controller_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [3:0]            z_element_ready;
  logic [3:0]            lane_ready;
  logic [ADDR_WIDTH-1:0] read_address;
  logic                  read_valid;
  logic                  read_ready;
  logic                  element_valid;
  logic                  cache_clear;
  logic                  vector_done;
  logic                  busy;
  logic                  overflow;

  modport master (
    input  z_element_ready,
    input  read_ready,
    output lane_ready,
    output read_address,
    output read_valid,
    output element_valid,
    output cache_clear,
    output vector_done,
    output busy,
    output overflow
  );

  modport slave (
    output z_element_ready,
    output read_ready,
    input  lane_ready,
    input  read_address,
    input  read_valid,
    input  element_valid,
    input  cache_clear,
    input  vector_done,
    input  busy,
    input  overflow
  );
endinterface

// File: rtl/second_stage_controller.sv
// rtl/second_stage_controller.sv - fill/drain sequencer for the four second-stage z-vector caches
// Counts per-lane writes, drains a full vector with shared read addresses, then clears for the next vector.
module second_stage_controller #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       en,
  second_stage_controller_if.master  bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [4:0]            FULL_COUNT = 5'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [3:0][4:0]       count;
  logic [3:0][4:0]       count_next;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  ovf;
  logic                  ovf_next;
  logic                  ev_q;
  logic                  ev_next;
  logic [3:0]            lane_full;
  logic                  all_full_next;
  logic                  active;

  // Outputs that represent requests or pulses are suppressed while disabled or in reset.
  assign active = en && !clear;

  always_comb begin
    lane_full = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      lane_full[i] = (count[i] == FULL_COUNT);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= FILL;
      count <= '0;
      addr  <= '0;
      ovf   <= 1'b0;
      ev_q  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      addr  <= addr_next;
      ovf   <= ovf_next;
      ev_q  <= ev_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    addr_next     = addr;
    ovf_next      = ovf;
    ev_next       = ev_q;
    all_full_next = 1'b1;

    // A pending element_valid is held across en=0 so the element is delivered once en returns.
    if (en) begin
      ev_next = 1'b0;
      case (state)
        FILL: begin
          for (int i = 0; i < 4; i++) begin
            if (bus.z_element_ready[i]) begin
              if (lane_full[i]) begin
                ovf_next = 1'b1;
              end else begin
                count_next[i] = count[i] + 5'd1;
              end
            end
            if (count_next[i] != FULL_COUNT) begin
              all_full_next = 1'b0;
            end
          end
          if (all_full_next) begin
            state_next = DRAIN;
          end
        end

        DRAIN: begin
          if (|bus.z_element_ready) begin
            ovf_next = 1'b1;
          end
          if (bus.read_ready) begin
            ev_next = 1'b1;
            if (addr == LAST_ADDR) begin
              addr_next  = '0;
              state_next = DONE;
            end else begin
              addr_next = addr + 1'b1;
            end
          end
        end

        DONE: begin
          if (|bus.z_element_ready) begin
            ovf_next = 1'b1;
          end
          count_next = '0;
          state_next = FILL;
        end

        default: begin
          state_next = FILL;
        end
      endcase
    end
  end

  assign bus.lane_ready    = (active && state == FILL) ? ~lane_full : 4'b0000;
  assign bus.read_address  = addr;
  assign bus.read_valid    = active && (state == DRAIN);
  assign bus.element_valid = active && ev_q;
  assign bus.cache_clear   = clear || (active && state == DONE);
  assign bus.vector_done   = active && (state == DONE);
  assign bus.busy          = (state == DRAIN) || (state == DONE);
  assign bus.overflow      = ovf;

endmodule
